// File: rtl/serial_rx_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// serial_rx_ctrl_pkg
// Shared definitions for the bit-serial receive path. The state encoding is
// also used by the line sampler and by debug logic, so the numeric values are
// fixed: IDLE=0, DATA=1, STOP=2, ERR=3.
// ---------------------------------------------------------------------------
package serial_rx_ctrl_pkg;

    // Default number of data bits per frame.
    localparam int DATA_BITS_DEF = 8;

    // Frame controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_STOP = 2'd2,
        ST_ERR  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/serial_rx_ctrl_byte_buffer.sv
// ---------------------------------------------------------------------------
// rx_byte_buffer
// One-entry valid/ready holding register for received bytes, with sticky
// overrun detection.
//
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   push_i        - a completed byte is offered this cycle
//   push_data_i   - the completed byte
//   clr_i         - clears the sticky overrun flag (a coincident drop wins)
//   rx_ready      - consumer accepts rx_data when rx_valid & rx_ready
//   rx_data       - held byte, stable while rx_valid=1 and not accepted
//   rx_valid      - rx_data holds an unconsumed byte
//   overrun       - sticky: a pushed byte was dropped because the entry was full
//
// Handshake: a transfer happens on a rising edge where rx_valid & rx_ready.
// A push in the same cycle as a transfer refills the entry.
// ---------------------------------------------------------------------------
module rx_byte_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         clr_i,
    input  logic         rx_ready,
    output logic [W-1:0] rx_data,
    output logic         rx_valid,
    output logic         overrun
);

    logic [W-1:0] data_q;
    logic         valid_q;
    logic         ovr_q;
    logic         can_load;
    logic         drop;

    // The entry is free if empty or being drained in this very cycle.
    assign can_load = !valid_q || rx_ready;
    assign drop     = push_i && !can_load;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (push_i && can_load) begin
                data_q  <= push_data_i;
                valid_q <= 1'b1;
            end else if (valid_q && rx_ready) begin
                valid_q <= 1'b0;
            end

            if (drop) begin
                ovr_q <= 1'b1;
            end else if (clr_i) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign rx_data  = data_q;
    assign rx_valid = valid_q;
    assign overrun  = ovr_q;

endmodule

// File: rtl/serial_rx_ctrl.sv
// ---------------------------------------------------------------------------
// serial_rx_ctrl
// Frame controller for the bit-serial receive path. Sequences start/data/stop
// framing on qualified bit strobes, assembles data bits LSB-first and hands
// each byte to the consumer through rx_byte_buffer.
//
// Ports:
//   clk, reset_n - clock, asynchronous active-low reset
//   bit_en       - sample strobe; rx_in is only evaluated when bit_en=1
//   rx_in        - serial line level (idle=1, start=0, stop=1)
//   rx_data      - buffered received byte
//   rx_valid     - rx_data holds an unconsumed byte
//   rx_ready     - consumer accepts rx_data when rx_valid & rx_ready
//   frame_err    - one-cycle pulse on a bad stop bit
//   overrun      - sticky; a completed byte was dropped (buffer full)
//   err_cnt      - saturating count of framing errors
//   err_clr      - clears overrun and err_cnt (a coincident set wins)
//   busy         - FSM not in IDLE
//   dbg_state    - current FSM state (serial_rx_ctrl_pkg encoding)
// ---------------------------------------------------------------------------
module serial_rx_ctrl
    import serial_rx_ctrl_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 bit_en,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 err_clr,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    localparam int CNT_W = $clog2(DATA_BITS);

    rx_state_e            state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 frame_err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [ERR_CNT_W-1:0] err_cnt_d;
    logic                 stop_ok;
    logic                 stop_bad;

    assign stop_ok  = bit_en && (state_q == ST_STOP) && rx_in;
    assign stop_bad = bit_en && (state_q == ST_STOP) && !rx_in;

    // A framing error in the same cycle as err_clr leaves a count of one.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (stop_bad) begin
            if (err_clr) begin
                err_cnt_d = ERR_CNT_W'(1);
            end else if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
        end else if (err_clr) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            frame_err_q <= stop_bad;
            err_cnt_q   <= err_cnt_d;
            if (bit_en) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!rx_in) begin
                            state_q <= ST_DATA;
                            cnt_q   <= '0;
                        end
                    end
                    ST_DATA: begin
                        // Right shift: the first data bit lands in bit 0.
                        shift_q <= {rx_in, shift_q[DATA_BITS-1:1]};
                        if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
                            state_q <= ST_STOP;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_STOP: begin
                        state_q <= rx_in ? ST_IDLE : ST_ERR;
                    end
                    ST_ERR: begin
                        // Only a mark level resynchronises; a 0 never starts a frame here.
                        if (rx_in) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    rx_byte_buffer #(
        .W (DATA_BITS)
    ) u_buf (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (stop_ok),
        .push_data_i (shift_q),
        .clr_i       (err_clr),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .overrun     (overrun)
    );

    assign frame_err = frame_err_q;
    assign err_cnt   = err_cnt_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_rx_ctrl
// Directed bench for serial_rx_ctrl. Drivers push the bytes they expect to be
// accepted into exp_q; a monitor pops on every rx_valid & rx_ready transfer.
// ---------------------------------------------------------------------------
module tb_serial_rx_ctrl;

    localparam int DB = 8;
    localparam int EW = 8;

    logic          clk;
    logic          reset_n;
    logic          bit_en;
    logic          rx_in;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          frame_err;
    logic          overrun;
    logic [EW-1:0] err_cnt;
    logic          err_clr;
    logic          busy;
    logic [1:0]    dbg_state;

    logic [DB-1:0] exp_q[$];
    int            n_cmp;
    int            n_err;

    serial_rx_ctrl #(
        .DATA_BITS (DB),
        .ERR_CNT_W (EW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bit_en    (bit_en),
        .rx_in     (rx_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_cnt   (err_cnt),
        .err_clr   (err_clr),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted byte must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset_n && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_byte: got 0x%0h, expected none at %0t", rx_data, $time);
            end else begin
                check("rx_byte", 32'(rx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic v, input int gap);
        bit_en = 1'b1;
        rx_in  = v;
        tick();
        bit_en = 1'b0;
        rx_in  = 1'b1;
        repeat (gap) tick();
    endtask

    // Start bit + LSB-first data bits; stop bit is driven separately.
    task automatic send_head(input logic [DB-1:0] d, input int gap);
        strobe(1'b0, gap);
        for (int i = 0; i < DB; i++) strobe(d[i], gap);
    endtask

    // Stop bit strobe, optionally with err_clr in the same cycle. Returns at
    // 1 time unit after the edge that consumed it, with bit_en low.
    task automatic send_stop(input logic v, input logic clr);
        bit_en  = 1'b1;
        rx_in   = v;
        err_clr = clr;
        tick();
        bit_en  = 1'b0;
        rx_in   = 1'b1;
        err_clr = 1'b0;
    endtask

    // Watchdog
    initial begin
        #500000;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        n_cmp    = 0;
        n_err    = 0;
        reset_n  = 1'b0;
        bit_en   = 1'b0;
        rx_in    = 1'b1;
        rx_ready = 1'b1;
        err_clr  = 1'b0;
        #12;
        check("rst_valid", 32'(rx_valid), 0);
        check("rst_data", 32'(rx_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_errcnt", 32'(err_cnt), 0);
        check("rst_overrun", 32'(overrun), 0);
        reset_n = 1'b1;
        tick();

        // 1: 0xA5 with a strobe every clock.
        exp_q.push_back(8'hA5);
        send_head(8'hA5, 0);
        check("s1_busy_stop", 32'(busy), 1);
        send_stop(1'b1, 1'b0);
        check("s1_valid_lat", 32'(rx_valid), 1);
        check("s1_data", 32'(rx_data), 32'hA5);
        check("s1_ferr", 32'(frame_err), 0);
        check("s1_busy", 32'(busy), 0);
        tick();
        check("s1_valid_drop", 32'(rx_valid), 0);

        // 2: 0x3C with a strobe every 4th clock.
        exp_q.push_back(8'h3C);
        strobe(1'b0, 3);
        check("s2_state_hold", 32'(dbg_state), 1);
        for (int i = 0; i < DB; i++) strobe(((8'h3C >> i) & 8'h01) != 0, 3);
        check("s2_state_stop", 32'(dbg_state), 2);
        send_stop(1'b1, 1'b0);
        check("s2_valid", 32'(rx_valid), 1);
        check("s2_data", 32'(rx_data), 32'h3C);
        tick();
        check("s2_valid_pulse", 32'(rx_valid), 0);

        // 3: 0x12 with a bad stop bit; zeros in ERR must not start a frame.
        send_head(8'h12, 0);
        send_stop(1'b0, 1'b0);
        check("s3_ferr", 32'(frame_err), 1);
        check("s3_errcnt", 32'(err_cnt), 1);
        check("s3_valid", 32'(rx_valid), 0);
        check("s3_busy", 32'(busy), 1);
        tick();
        check("s3_ferr_pulse", 32'(frame_err), 0);
        strobe(1'b0, 0);
        strobe(1'b0, 0);
        check("s3_err_hold", 32'(dbg_state), 3);
        strobe(1'b1, 0);
        check("s3_busy_done", 32'(busy), 0);

        // 4: two frames with the consumer stalled.
        rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_head(8'h11, 0);
        send_stop(1'b1, 1'b0);
        send_head(8'h22, 0);
        send_stop(1'b1, 1'b0);
        check("s4_overrun", 32'(overrun), 1);
        check("s4_data_kept", 32'(rx_data), 32'h11);
        check("s4_valid", 32'(rx_valid), 1);
        rx_ready = 1'b1;
        tick();
        check("s4_valid_drop", 32'(rx_valid), 0);

        // 5: saturate the error counter (currently 1), then clear.
        for (int i = 0; i < 254; i++) begin
            send_head(8'h00, 0);
            send_stop(1'b0, 1'b0);
            strobe(1'b1, 0);
        end
        check("s5_sat", 32'(err_cnt), 32'hFF);
        send_head(8'h00, 0);
        send_stop(1'b0, 1'b0);
        strobe(1'b1, 0);
        check("s5_sat_hold", 32'(err_cnt), 32'hFF);
        send_head(8'h00, 0);
        send_stop(1'b0, 1'b1);
        check("s5_clr_coinc", 32'(err_cnt), 1);
        strobe(1'b1, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("s5_clr_cnt", 32'(err_cnt), 0);
        check("s5_clr_ovr", 32'(overrun), 0);

        // 6: leave state behind, then reset asynchronously mid-DATA.
        rx_ready = 1'b0;
        send_head(8'h77, 0);
        send_stop(1'b1, 1'b0);
        send_head(8'h01, 0);
        send_stop(1'b0, 1'b0);
        strobe(1'b1, 0);
        check("s6_pre_valid", 32'(rx_valid), 1);
        check("s6_pre_errcnt", 32'(err_cnt), 1);
        strobe(1'b0, 0);
        for (int i = 0; i < 4; i++) strobe(1'b1, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("s6_rst_valid", 32'(rx_valid), 0);
        check("s6_rst_data", 32'(rx_data), 0);
        check("s6_rst_errcnt", 32'(err_cnt), 0);
        check("s6_rst_busy", 32'(busy), 0);
        check("s6_rst_ferr", 32'(frame_err), 0);
        check("s6_rst_ovr", 32'(overrun), 0);
        tick();
        reset_n  = 1'b1;
        rx_ready = 1'b1;
        tick();
        exp_q.push_back(8'h5A);
        send_head(8'h5A, 0);
        send_stop(1'b1, 1'b0);
        check("s6_data", 32'(rx_data), 32'h5A);
        check("s6_valid", 32'(rx_valid), 1);

        repeat (5) tick();
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_rx_ctrl.md
Name: serial_rx_ctrl

Overview:
Frame controller for the bit-serial receive path. It sequences start/data/stop framing on qualified bit strobes and assembles the data bits LSB-first into a byte. It hands each byte to the consumer over a valid/ready buffer and records framing and overrun errors. It sits between the line sampler, which produces rx_in and bit_en, and the downstream byte consumer.

Parameters:
DATA_BITS, 8, data bits per frame (range 5..9).
ERR_CNT_W, 8, width of the saturating frame-error counter.

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
bit_en  input  1  sample strobe; rx_in is evaluated only on cycles with bit_en=1
rx_in  input  1  serial line level (idle=1, start=0, stop=1)
rx_data  output  DATA_BITS  buffered received byte
rx_valid  output  1  rx_data holds an unconsumed byte
rx_ready  input  1  consumer accepts rx_data when rx_valid&rx_ready
frame_err  output  1  one-cycle pulse on a bad stop bit
overrun  output  1  sticky; a completed byte was dropped because the buffer was full
err_cnt  output  ERR_CNT_W  saturating count of framing errors
err_clr  input  1  clears overrun and err_cnt
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (async, reset_n=0): state=IDLE, bit count=0, shift reg=0, rx_data=0, rx_valid=0, frame_err=0, overrun=0, err_cnt=0. Reset mid-frame discards the partial byte.
- Clock domain: single clk; bit_en is already synchronous.
- FSM states: IDLE, DATA, STOP, ERR. Transitions occur only on cycles with bit_en=1; otherwise state, count and shift reg hold.
  - IDLE: rx_in=0 -> DATA with count=0; rx_in=1 -> stay in IDLE.
  - DATA: shift rx_in into the MSB of the shift reg (right shift, so the first bit ends at bit 0), then count++. When count==DATA_BITS-1 on that strobe -> STOP.
  - STOP: rx_in=1 -> deliver the byte, then IDLE. rx_in=0 -> ERR, frame_err=1 for one cycle, err_cnt+1 (saturates at all-ones). No byte is delivered.
  - ERR: remain until a strobe with rx_in=1 -> IDLE. A 0 level never restarts a frame from ERR.
- Back-to-back frames: a start bit on the strobe immediately after a good stop bit is accepted from IDLE.
- Delivery (at the STOP strobe clock edge):
  - If rx_valid=0, or rx_valid&rx_ready in the same cycle: rx_data<=shift reg and rx_valid=1 from the next cycle. Latency is 1 clk after the stop-bit strobe.
  - If rx_valid=1 and rx_ready=0: the new byte is dropped, rx_data is unchanged, and overrun<=1.
- Handshake: rx_valid deasserts the cycle after rx_valid&rx_ready unless a delivery coincides. rx_data is stable while rx_valid=1 and not accepted.
- err_clr: zeroes overrun and err_cnt on the next edge. If a framing error or overrun occurs in the same cycle, the set wins: overrun=1, err_cnt=1.
- busy=1 in DATA, STOP and ERR.
- All outputs are registered except busy, which is decoded from the state.

Decomposition:
- Shared package: the FSM state encoding constants IDLE=0, DATA=1, STOP=2, ERR=3 (2 bits), shared with the sampler and debug logic, plus the default DATA_BITS value.
- Optional sub-module rx_byte_buffer: the one-entry valid/ready holding register with overrun detection. The FSM, counter and shift register stay in serial_rx_ctrl.

Test Plan:
1. Byte 0xA5 with bit_en every clk: rx_in=0, then 1,0,1,0,0,1,0,1, then 1. Required: rx_valid=1 one clk after the stop strobe, rx_data=0xA5, frame_err never asserted, busy=0 afterward.
2. bit_en every 4th clk, byte 0x3C, rx_ready held 1. Required: same result as scenario 1. Non-strobe cycles do not advance the FSM; rx_valid pulses for one cycle.
3. Frame 0x12 with stop bit=0. Required: frame_err single-cycle pulse, err_cnt=1, no rx_valid, busy=1 until the next strobe with rx_in=1. Zero levels in ERR do not start a frame.
4. Two frames 0x11 then 0x22 with rx_ready=0. Required: rx_data=0x11 retained and overrun=1. Then raise rx_ready: accept 0x11, rx_valid drops.
5. 256+ framing errors with ERR_CNT_W=8. Required: err_cnt saturates at 0xFF. Assert err_clr coincident with another frame error. Required: err_cnt=1, and after a lone err_clr, err_cnt=0 and overrun=0.
6. Assert reset_n=0 asynchronously mid-DATA (after 4 bits), then release and send 0x5A. Required: all outputs 0 immediately during reset, and the next frame decodes 0x5A correctly.
